// File: rtl/keypad_encoder_pkg.sv
// -----------------------------------------------------------------------------
// keypad_encoder_pkg
//   Shared definitions for the 10-key digit interface: key/digit widths, the
//   "no key pressed" pattern of the active-low keypad vector and the encoder
//   FSM state type.
// -----------------------------------------------------------------------------
package keypad_encoder_pkg;

    localparam int KEY_W   = 10;
    localparam int DIGIT_W = 4;

    // All lines high: nothing pressed (keypad lines are active-low).
    localparam logic [KEY_W-1:0] KEY_NONE = 10'h3FF;

    typedef enum logic [2:0] {
        IDLE,
        DEB,
        HELD,
        REL,
        WAITREL
    } kp_state_e;

endpackage

// File: rtl/keypad_encoder_onehot_enc.sv
// -----------------------------------------------------------------------------
// key_onehot_enc
//   Combinational classifier for the synchronized active-low key vector.
//   Ports:
//     s      in  [KEY_W-1:0]   synchronized key lines, active-low
//     none   out               no key pressed
//     single out               exactly one key pressed
//     multi  out               two or more keys pressed
//     digit  out [DIGIT_W-1:0] index of the pressed key; meaningful only
//                              while single=1
// -----------------------------------------------------------------------------
module key_onehot_enc
    import keypad_encoder_pkg::*;
(
    input  logic [KEY_W-1:0]   s,
    output logic               none,
    output logic               single,
    output logic               multi,
    output logic [DIGIT_W-1:0] digit
);

    logic [3:0] zeros;

    always_comb begin
        zeros = '0;
        digit = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (!s[i]) begin
                zeros = zeros + 4'd1;
                digit = DIGIT_W'(i);
            end
        end
        none   = (zeros == 4'd0);
        single = (zeros == 4'd1);
        multi  = (zeros > 4'd1);
    end

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//   Synchronizes and debounces the raw active-low keypad, rejects multi-key
//   presses and emits one digit event per accepted press.
//   Build option: define KEYPAD_REPEAT_EN to add auto-repeat while a key is
//   held (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
//   Ports:
//     clk        in        system clock (1 kHz)
//     rst        in        asynchronous reset, active-high
//     keypad_n   in  [9:0] raw key lines, active-low, bit i = key i
//     key_valid  out       one-cycle strobe: new digit on key_digit
//     key_digit  out [3:0] digit 0-9; holds the last value between strobes
//     key_held   out       high while an accepted key is held
//     multi_err  out       one-cycle strobe: two or more keys detected
// -----------------------------------------------------------------------------
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int DEB_CYCLES    = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   keypad_n,
    output logic               key_valid,
    output logic [DIGIT_W-1:0] key_digit,
    output logic               key_held,
    output logic               multi_err
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Degenerate configurations are left as a visible marker in the hierarchy.
    if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [KEY_W-1:0]   sync1_q, sync1_d;
    logic [KEY_W-1:0]   sync2_q, sync2_d;
    kp_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] cand_q, cand_d;
    logic               key_valid_q, key_valid_d;
    logic [DIGIT_W-1:0] key_digit_q, key_digit_d;
    logic               multi_err_q, multi_err_d;

    logic               cls_none, cls_single, cls_multi;
    logic [DIGIT_W-1:0] cls_digit;
    logic               same_key;

`ifdef KEYPAD_REPEAT_EN
    localparam int              REP_W     = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_WRAP  = REP_W'(REPEAT_DELAY + REPEAT_PERIOD);
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
`endif

    key_onehot_enc u_enc (
        .s      (sync2_q),
        .none   (cls_none),
        .single (cls_single),
        .multi  (cls_multi),
        .digit  (cls_digit)
    );

    assign same_key = cls_single && (cls_digit == cand_q);

    always_comb begin
        sync1_d     = keypad_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        key_digit_d = key_digit_q;
        multi_err_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
        rep_inc = rep_q + REP_W'(1);
`endif

        case (state_q)
            IDLE: begin
                if (cls_single) begin
                    state_d = DEB;
                    cand_d  = cls_digit;
                    cnt_d   = CNT_W'(1);
                end else if (cls_multi) begin
                    multi_err_d = 1'b1;
                    state_d     = WAITREL;
                    cnt_d       = '0;
                end
            end

            DEB: begin
                if (same_key) begin
                    if (cnt_q >= CNT_MAX) begin
                        key_valid_d = 1'b1;
                        key_digit_d = cand_q;
                        state_d     = HELD;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else if (cls_multi) begin
                    multi_err_d = 1'b1;
                    state_d     = WAITREL;
                    cnt_d       = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            HELD: begin
                if (cls_none) begin
                    state_d = REL;
                    cnt_d   = CNT_W'(1);
                end else if (cls_multi) begin
                    multi_err_d = 1'b1;
                    state_d     = WAITREL;
                    cnt_d       = '0;
                end else if (!same_key) begin
                    state_d = WAITREL;
                    cnt_d   = '0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    // Counter folds back to REP_FIRST so every later repeat
                    // lands on REP_WRAP.
                    if (rep_inc == REP_WRAP) begin
                        key_valid_d = 1'b1;
                        key_digit_d = cand_q;
                        rep_d       = REP_FIRST;
                    end else begin
                        rep_d = rep_inc;
                        if (rep_inc == REP_FIRST) begin
                            key_valid_d = 1'b1;
                            key_digit_d = cand_q;
                        end
                    end
`endif
                end
            end

            REL: begin
                if (cls_none) begin
                    if (cnt_q >= CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else if (same_key) begin
                    // Release bounce: resume holding without a new event.
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    state_d = WAITREL;
                    cnt_d   = '0;
                end
            end

            WAITREL: begin
                // cnt counts consecutive all-released samples.
                if (cls_none) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef KEYPAD_REPEAT_EN
        // The repeat count survives HELD<->REL bounce only.
        if (state_d != HELD && state_d != REL) begin
            rep_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= KEY_NONE;
            sync2_q     <= KEY_NONE;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_digit_q <= '0;
            multi_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_digit_q <= key_digit_d;
            multi_err_q <= multi_err_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign key_valid = key_valid_q;
    assign key_digit = key_digit_q;
    assign multi_err = multi_err_q;
    assign key_held  = (state_q == HELD) || (state_q == REL);

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
//   Self-checking bench for keypad_encoder (DEB_CYCLES=4). dut_a runs a
//   hand-derived segment table and a randomized segment stream against a
//   behavioural model; dut_b (REPEAT_DELAY=10, REPEAT_PERIOD=5) covers the
//   long hold and a reset in the middle of a hold.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_encoder;

    localparam int DEB  = 4;
    localparam int RD_A = 500;
    localparam int RP_A = 100;
    localparam int RD_B = 10;
    localparam int RP_B = 5;
    localparam logic [9:0] KEYS_UP = 10'h3FF;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [9:0] pins_a, pins_b;
    logic       valid_a, held_a, multi_a;
    logic [3:0] digit_a;
    logic       valid_b, held_b, multi_b;
    logic [3:0] digit_b;

    keypad_encoder #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP_A)) dut_a (
        .clk(clk), .rst(rst_a), .keypad_n(pins_a),
        .key_valid(valid_a), .key_digit(digit_a), .key_held(held_a), .multi_err(multi_a)
    );

    keypad_encoder #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP_B)) dut_b (
        .clk(clk), .rst(rst_b), .keypad_n(pins_b),
        .key_valid(valid_b), .key_digit(digit_b), .key_held(held_b), .multi_err(multi_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pk(input int a, input int b = -1);
        logic [9:0] v;
        v = KEYS_UP;
        v[a] = 1'b0;
        if (b >= 0) v[b] = 1'b0;
        return v;
    endfunction

    // ---------------- behavioural model of dut_a ----------------
    logic [9:0] m_s1, m_s2;
    int m_cand, m_run, m_rep;
    bit m_acc, m_rel, m_lock;
    bit e_valid, e_multi;
    int e_digit;

    task automatic model_reset();
        m_s1 = KEYS_UP; m_s2 = KEYS_UP;
        m_cand = -1; m_run = 0; m_rep = 0;
        m_acc = 0; m_rel = 0; m_lock = 0;
        e_valid = 0; e_multi = 0; e_digit = 0;
    endtask

    // One clock edge: the decision uses the key vector seen two edges ago.
    task automatic model_step(input logic [9:0] p);
        logic [9:0] s;
        int nz, k;
        s = m_s2; m_s2 = m_s1; m_s1 = p;
        e_valid = 0; e_multi = 0;
        nz = $countones(~s);
        k = -1;
        for (int i = 0; i < 10; i++) if (!s[i]) k = i;
        if (m_lock) begin
            if (nz == 0) begin
                m_run++;
                if (m_run >= DEB) begin m_lock = 0; m_run = 0; end
            end else m_run = 0;
        end else if (m_acc) begin
            if (nz == 1 && k == m_cand) begin
                if (m_rel) m_rel = 0;
                else begin
                    m_rep++;
                    if (REP_EN && (m_rep == RD_A || (m_rep > RD_A && (m_rep - RD_A) % RP_A == 0))) begin
                        e_valid = 1; e_digit = m_cand;
                    end
                end
            end else if (nz == 0) begin
                if (!m_rel) begin m_rel = 1; m_run = 1; end
                else if (m_run >= DEB) begin m_acc = 0; m_rel = 0; m_cand = -1; m_run = 0; end
                else m_run++;
            end else begin
                if (nz > 1 && !m_rel) e_multi = 1;
                m_acc = 0; m_rel = 0; m_cand = -1; m_lock = 1; m_run = 0;
            end
        end else if (m_cand >= 0) begin
            if (nz == 1 && k == m_cand) begin
                if (m_run >= DEB) begin
                    e_valid = 1; e_digit = m_cand; m_acc = 1; m_rel = 0; m_rep = 0; m_run = 0;
                end else m_run++;
            end else if (nz > 1) begin
                e_multi = 1; m_cand = -1; m_lock = 1; m_run = 0;
            end else begin
                m_cand = -1; m_run = 0;
            end
        end else begin
            if (nz == 1) begin m_cand = k; m_run = 1; end
            else if (nz > 1) begin e_multi = 1; m_lock = 1; m_run = 0; end
        end
    endtask

    task automatic rand_cycle(input logic [9:0] p);
        pins_a = p;
        @(posedge clk);
        model_step(p);
        @(negedge clk);
        check("rand_valid", valid_a, e_valid);
        check("rand_multi", multi_a, e_multi);
        check("rand_held",  held_a,  m_acc);
        check("rand_digit", digit_a, e_digit);
    endtask

    // ---------------- segment table ----------------
    typedef struct {
        logic [9:0] pins;
        int cycles;
        int n_valid;
        int n_multi;
        int digit_end;
        int n_held;
        bit held_end;
    } row_t;
    row_t tbl[$];

    task automatic add_row(input logic [9:0] p, input int cyc, input int nv, input int nm,
                           input int dig, input int nh, input bit he);
        row_t r;
        r.pins = p; r.cycles = cyc; r.n_valid = nv; r.n_multi = nm;
        r.digit_end = dig; r.n_held = nh; r.held_end = he;
        tbl.push_back(r);
    endtask

    int ev_q[$];
    int exp_ev[$];

    initial begin
        int nv, nm, nh, ov, sel, len, a, last_k;
        logic [9:0] p;

        rst_a = 1'b1; rst_b = 1'b1;
        pins_a = KEYS_UP; pins_b = KEYS_UP;

        //            pins        cyc nv nm dig held end
        add_row(KEYS_UP,     6,  0, 0, 0, 0,  0);
        add_row(pk(7),      20,  1, 0, 7, 14, 1);  // clean press
        add_row(KEYS_UP,     4,  0, 0, 7, 4,  1);  // release, still in REL
        add_row(KEYS_UP,     4,  0, 0, 7, 2,  0);  // 4 released samples done
        add_row(pk(3),       2,  0, 0, 7, 0,  0);  // press bounce
        add_row(KEYS_UP,     1,  0, 0, 7, 0,  0);
        add_row(pk(3),      12,  1, 0, 3, 6,  1);
        add_row(KEYS_UP,    10,  0, 0, 3, 6,  0);
        add_row(pk(9),       3,  0, 0, 3, 0,  0);  // too short
        add_row(KEYS_UP,    10,  0, 0, 3, 0,  0);
        add_row(pk(2),      12,  1, 0, 2, 6,  1);
        add_row(KEYS_UP,     2,  0, 0, 2, 2,  1);  // release bounce
        add_row(pk(2),      10,  0, 0, 2, 10, 1);
        add_row(KEYS_UP,    10,  0, 0, 2, 6,  0);
        add_row(pk(1, 5),    6,  0, 1, 2, 0,  0);  // two keys
        add_row(KEYS_UP,     8,  0, 0, 2, 0,  0);
        add_row(pk(0),      12,  1, 0, 0, 6,  1);
        add_row(KEYS_UP,    10,  0, 0, 0, 6,  0);
        add_row(pk(6),       8,  1, 0, 6, 2,  1);
        add_row(pk(8),       8,  0, 0, 6, 2,  0);  // other key while held
        add_row(KEYS_UP,     8,  0, 0, 6, 0,  0);

        repeat (2) @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_held",  held_a,  0);
        check("rst_multi", multi_a, 0);
        check("rst_digit", digit_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // ---- table ----
        for (int r = 0; r < tbl.size(); r++) begin
            nv = 0; nm = 0; nh = 0; ov = 0;
            pins_a = tbl[r].pins;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (valid_a) nv++;
                if (multi_a) nm++;
                if (held_a) nh++;
                if (valid_a && multi_a) ov++;
            end
            check($sformatf("row%0d_valid_cnt", r), nv, tbl[r].n_valid);
            check($sformatf("row%0d_multi_cnt", r), nm, tbl[r].n_multi);
            check($sformatf("row%0d_held_cnt", r), nh, tbl[r].n_held);
            check($sformatf("row%0d_held_end", r), held_a, tbl[r].held_end);
            check($sformatf("row%0d_digit", r), digit_a, tbl[r].digit_end);
            check($sformatf("row%0d_overlap", r), ov, 0);
        end

        // ---- randomized segments against the model ----
        pins_a = KEYS_UP;
        rst_a = 1'b1;
        model_reset();
        @(negedge clk);
        rst_a = 1'b0;
        last_k = 0;
        for (int seg = 0; seg < 150; seg++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 12);
            if (sel < 4) p = KEYS_UP;
            else if (sel < 7) begin
                last_k = $urandom_range(0, 9);
                p = pk(last_k);
            end else if (sel < 9) p = pk(last_k);
            else begin
                a = $urandom_range(0, 9);
                p = pk(a, (a + $urandom_range(1, 9)) % 10);
            end
            for (int c = 0; c < len; c++) rand_cycle(p);
        end

        // ---- long hold on dut_b ----
        pins_b = pk(4);
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_b) begin
                ev_q.push_back(j);
                check("hold_digit", digit_b, 4);
            end
            check("hold_overlap", valid_b && multi_b, 0);
        end
        exp_ev.push_back(DEB + 2);
        if (REP_EN) begin
            for (int t = DEB + 2 + RD_B; t < 40; t += RP_B) exp_ev.push_back(t);
        end
        check("hold_event_count", ev_q.size(), exp_ev.size());
        for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++)
            check($sformatf("hold_event%0d_cycle", i), ev_q[i], exp_ev[i]);
        check("hold_held", held_b, 1);

        // ---- asynchronous reset in the middle of the hold ----
        #2;
        rst_b = 1'b1;
        #1;
        check("midrst_valid", valid_b, 0);
        check("midrst_held",  held_b,  0);
        check("midrst_multi", multi_b, 0);
        check("midrst_digit", digit_b, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        ev_q.delete();
        for (int j = 0; j < 14; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_b) begin
                ev_q.push_back(j);
                check("repress_digit", digit_b, 4);
            end
        end
        check("repress_count", ev_q.size(), 1);
        if (ev_q.size() > 0) check("repress_cycle", ev_q[0], DEB + 2);
        check("repress_held", held_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
